// File: rtl/iob_pbus_guard.sv
// Per-slave IOb guard: forwards one request at a time, times out dead peripherals.
// Build option IOB_PBUS_GUARD_ERR_CNT_EN adds the saturating err_cnt_o counter.

module iob_pbus_guard #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 256,
  parameter int TIMEOUT_W = 9,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cke_i,
  input  logic                  m_avalid_i,
  input  logic [ADDR_W-1:0]     m_addr_i,
  input  logic [DATA_W-1:0]     m_wdata_i,
  input  logic [DATA_W/8-1:0]   m_wstrb_i,
  output logic [DATA_W-1:0]     m_rdata_o,
  output logic                  m_rvalid_o,
  output logic                  m_ready_o,
  output logic                  s_avalid_o,
  output logic [ADDR_W-1:0]     s_addr_o,
  output logic [DATA_W-1:0]     s_wdata_o,
  output logic [DATA_W/8-1:0]   s_wstrb_o,
  input  logic [DATA_W-1:0]     s_rdata_i,
  input  logic                  s_rvalid_i,
  input  logic                  s_ready_i,
  output logic                  err_o,
  output logic [ADDR_W-1:0]     err_addr_o,
`ifdef IOB_PBUS_GUARD_ERR_CNT_EN
  output logic [7:0]            err_cnt_o,
`endif
  input  logic                  err_clr_i
);

  localparam int SW = DATA_W / 8;
  localparam logic [TIMEOUT_W-1:0] CNT_LAST =
    TIMEOUT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    RDATA = 2'd2
  } state_t;

  state_t state, state_n;

  logic [TIMEOUT_W-1:0] cnt, cnt_n;

  logic              is_rd;
  logic              last;
  logic              accept;
  logic              done_wr;
  logic              done_rd;
  logic              to_rdata;
  logic              tmo;

  logic              m_ready_n;
  logic              m_rvalid_n;
  logic [DATA_W-1:0] m_rdata_n;
  logic              s_avalid_n;
  logic [ADDR_W-1:0] s_addr_n;
  logic [DATA_W-1:0] s_wdata_n;
  logic [SW-1:0]     s_wstrb_n;
  logic              err_n;
  logic [ADDR_W-1:0] err_addr_n;

  assign is_rd  = (s_wstrb_o == '0);
  assign last   = (cnt == CNT_LAST);
  assign accept = (state == IDLE) && m_ready_o
               && m_avalid_i;

  assign done_wr = (state == ACK) && s_ready_i
                && !is_rd;

  assign done_rd =
    ((state == ACK) && s_ready_i && is_rd && s_rvalid_i)
    || ((state == RDATA) && s_rvalid_i);

  // an ack-only read on the final cycle still times out
  assign to_rdata = (state == ACK) && s_ready_i && is_rd
                 && !s_rvalid_i && !last;

  assign tmo = ((state == ACK) || (state == RDATA))
            && last && !done_wr && !done_rd;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else if (cke_i) begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept) state_n = ACK;
      end
      ACK: begin
        if (done_wr || done_rd || tmo) begin
          state_n = IDLE;
        end else if (to_rdata) begin
          state_n = RDATA;
        end
      end
      RDATA: begin
        if (done_rd || tmo) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    m_ready_n  = (state_n == IDLE);
    s_avalid_n = (state_n == ACK);
    m_rvalid_n = done_rd || (tmo && is_rd);

    unique case (1'b1)
      done_rd:       m_rdata_n = s_rdata_i;
      tmo && is_rd:  m_rdata_n = ERR_DATA;
      default:       m_rdata_n = m_rdata_o;
    endcase

    s_addr_n  = accept ? m_addr_i  : s_addr_o;
    s_wdata_n = accept ? m_wdata_i : s_wdata_o;
    s_wstrb_n = accept ? m_wstrb_i : s_wstrb_o;

    if (accept) begin
      cnt_n = '0;
    end else if (state != IDLE) begin
      cnt_n = cnt + TIMEOUT_W'(1);
    end else begin
      cnt_n = cnt;
    end

    err_n      = tmo || (err_o && !err_clr_i);
    err_addr_n = (tmo && !err_o) ? s_addr_o
                                 : err_addr_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      m_ready_o  <= 1'b0;
      m_rvalid_o <= 1'b0;
      m_rdata_o  <= '0;
      s_avalid_o <= 1'b0;
      s_addr_o   <= '0;
      s_wdata_o  <= '0;
      s_wstrb_o  <= '0;
      cnt        <= '0;
      err_o      <= 1'b0;
      err_addr_o <= '0;
    end else if (cke_i) begin
      m_ready_o  <= m_ready_n;
      m_rvalid_o <= m_rvalid_n;
      m_rdata_o  <= m_rdata_n;
      s_avalid_o <= s_avalid_n;
      s_addr_o   <= s_addr_n;
      s_wdata_o  <= s_wdata_n;
      s_wstrb_o  <= s_wstrb_n;
      cnt        <= cnt_n;
      err_o      <= err_n;
      err_addr_o <= err_addr_n;
    end
  end

`ifdef IOB_PBUS_GUARD_ERR_CNT_EN
  logic [7:0] err_cnt_n;

  always_comb begin
    if (tmo) begin
      if (err_clr_i) begin
        err_cnt_n = 8'd1;
      end else if (err_cnt_o == 8'hFF) begin
        err_cnt_n = err_cnt_o;
      end else begin
        err_cnt_n = err_cnt_o + 8'd1;
      end
    end else if (err_clr_i) begin
      err_cnt_n = 8'd0;
    end else begin
      err_cnt_n = err_cnt_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      err_cnt_o <= 8'd0;
    end else if (cke_i) begin
      err_cnt_o <= err_cnt_n;
    end
  end
`else
  // timeouts are only flagged through err_o in this build
`endif

endmodule

// File: tb/tb_iob_pbus_guard.sv
// Bench for iob_pbus_guard: vector table, directed corner cases,
// then random traffic against a transaction-level reference model.

module tb_iob_pbus_guard;

  localparam int TMO = 8;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cke;
  logic        m_avalid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_ready;
  logic        s_avalid;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata;
  logic        s_rvalid;
  logic        s_ready;
  logic        err;
  logic [31:0] err_addr;
  logic        err_clr;
`ifdef IOB_PBUS_GUARD_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int nchk = 0;
  int nerr = 0;

  iob_pbus_guard #(
    .ADDR_W(32), .DATA_W(32),
    .TIMEOUT(TMO), .TIMEOUT_W(4)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke),
    .m_avalid_i(m_avalid), .m_addr_i(m_addr),
    .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
    .m_rdata_o(m_rdata), .m_rvalid_o(m_rvalid),
    .m_ready_o(m_ready), .s_avalid_o(s_avalid),
    .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_wstrb_o(s_wstrb), .s_rdata_i(s_rdata),
    .s_rvalid_i(s_rvalid), .s_ready_i(s_ready),
    .err_o(err), .err_addr_o(err_addr),
`ifdef IOB_PBUS_GUARD_ERR_CNT_EN
    .err_cnt_o(err_cnt),
`endif
    .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic idle_in();
    m_avalid = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0;
    s_ready = 0; s_rvalid = 0; s_rdata = 0; err_clr = 0;
  endtask

  task automatic issue(logic [31:0] a, logic [3:0] ws);
    m_avalid = 1; m_addr = a; m_wdata = a + 1; m_wstrb = ws;
    tick();
    m_avalid = 0;
  endtask

  typedef struct {
    logic av; logic [31:0] addr; logic [31:0] wd;
    logic [3:0] ws; logic sr; logic sv; logic [31:0] sd;
    logic e_rdy; logic e_rv; logic [31:0] e_rd;
    logic e_sav; logic [31:0] e_sad; logic [31:0] e_swd;
    logic [3:0] e_sws; logic e_err;
  } vec_t;

  vec_t tbl[15];

  // reference model: one in-flight transaction aged in cycles
  bit          busy, acked, p_wr;
  int          age;
  logic        e_rdy, e_rv, e_sav, e_err;
  logic [31:0] e_rd, e_sad, e_swd, e_ead;
  logic [3:0]  e_sws;
  int          e_cnt;

  task automatic model_step();
    bit done, tmo;
    done = 0; tmo = 0;
    if (!rst_n) begin
      busy = 0; acked = 0; age = 0;
      e_rdy = 0; e_rv = 0; e_sav = 0; e_err = 0;
      e_rd = 0; e_sad = 0; e_swd = 0; e_sws = 0;
      e_ead = 0; e_cnt = 0;
    end else if (cke) begin
      e_rv = 0;
      if (!busy) begin
        if (e_rdy && m_avalid) begin
          busy = 1; acked = 0; age = 1;
          p_wr = (m_wstrb != 0);
          e_sad = m_addr; e_swd = m_wdata; e_sws = m_wstrb;
          e_sav = 1; e_rdy = 0;
        end else begin
          e_rdy = 1;
        end
      end else begin
        if (!acked && s_ready) begin
          if (p_wr) done = 1;
          else if (s_rvalid) begin
            done = 1; e_rv = 1; e_rd = s_rdata;
          end else acked = 1;
        end else if (acked && s_rvalid) begin
          done = 1; e_rv = 1; e_rd = s_rdata;
        end
        if (!done && age == TMO) begin
          tmo = 1; done = 1;
          if (!p_wr) begin e_rv = 1; e_rd = ERRD; end
          if (!e_err) e_ead = e_sad;
        end
        if (done) begin
          busy = 0; e_sav = 0; e_rdy = 1;
        end else begin
          if (acked) e_sav = 0;
          age++;
        end
      end
      if (tmo) e_cnt = err_clr ? 1 : (e_cnt < 255 ? e_cnt + 1 : 255);
      else if (err_clr) e_cnt = 0;
      e_err = tmo ? 1'b1 : (err_clr ? 1'b0 : e_err);
    end
  endtask

  initial begin
    tbl[0]  = '{0,0,0,0,0,0,0,            1,0,0,0,0,0,0,0};
    tbl[1]  = '{1,32'h10,32'h1234,4'hF,0,0,0, 0,0,0,1,32'h10,32'h1234,4'hF,0};
    tbl[2]  = '{0,0,0,0,0,0,0,            0,0,0,1,32'h10,32'h1234,4'hF,0};
    tbl[3]  = '{0,0,0,0,0,0,0,            0,0,0,1,32'h10,32'h1234,4'hF,0};
    tbl[4]  = '{0,0,0,0,1,0,0,            1,0,0,0,32'h10,32'h1234,4'hF,0};
    tbl[5]  = '{1,32'h20,0,0,0,0,0,       0,0,0,1,32'h20,0,0,0};
    tbl[6]  = '{0,0,0,0,1,0,0,            0,0,0,0,32'h20,0,0,0};
    tbl[7]  = '{0,0,0,0,0,0,0,            0,0,0,0,32'h20,0,0,0};
    tbl[8]  = '{0,0,0,0,0,0,0,            0,0,0,0,32'h20,0,0,0};
    tbl[9]  = '{0,0,0,0,0,1,32'hCAFE0001, 1,1,32'hCAFE0001,0,32'h20,0,0,0};
    tbl[10] = '{0,0,0,0,0,0,0,            1,0,32'hCAFE0001,0,32'h20,0,0,0};
    tbl[11] = '{1,32'h24,0,0,0,0,0,       0,0,32'hCAFE0001,1,32'h24,0,0,0};
    tbl[12] = '{0,0,0,0,1,1,32'h55,       1,1,32'h55,0,32'h24,0,0,0};
    tbl[13] = '{0,0,0,0,0,0,0,            1,0,32'h55,0,32'h24,0,0,0};
    tbl[14] = '{0,0,0,0,1,1,32'h77,       1,0,32'h55,0,32'h24,0,0,0};

    idle_in();
    cke = 1; rst_n = 0;
    tick();
    chk("rst_rdy", m_ready, 0);
    chk("rst_rv", m_rvalid, 0);
    chk("rst_sav", s_avalid, 0);
    chk("rst_err", err, 0);
    chk("rst_rd", m_rdata, 0);
    rst_n = 1;

    for (int i = 0; i < 15; i++) begin
      m_avalid = tbl[i].av; m_addr = tbl[i].addr;
      m_wdata = tbl[i].wd; m_wstrb = tbl[i].ws;
      s_ready = tbl[i].sr; s_rvalid = tbl[i].sv;
      s_rdata = tbl[i].sd;
      tick();
      chk($sformatf("v%0d_rdy", i), m_ready, tbl[i].e_rdy);
      chk($sformatf("v%0d_rv", i), m_rvalid, tbl[i].e_rv);
      chk($sformatf("v%0d_rd", i), m_rdata, tbl[i].e_rd);
      chk($sformatf("v%0d_sav", i), s_avalid, tbl[i].e_sav);
      chk($sformatf("v%0d_sad", i), s_addr, tbl[i].e_sad);
      chk($sformatf("v%0d_swd", i), s_wdata, tbl[i].e_swd);
      chk($sformatf("v%0d_sws", i), s_wstrb, tbl[i].e_sws);
      chk($sformatf("v%0d_err", i), err, tbl[i].e_err);
    end
    idle_in();

    // silent read peripheral
    issue(32'h30, 4'h0);
    repeat (TMO - 1) tick();
    chk("tmo_wait_sav", s_avalid, 1);
    chk("tmo_wait_rv", m_rvalid, 0);
    tick();
    chk("tmo_rv", m_rvalid, 1);
    chk("tmo_rd", m_rdata, ERRD);
    chk("tmo_err", err, 1);
    chk("tmo_eaddr", err_addr, 32'h30);
    chk("tmo_rdy", m_ready, 1);
    chk("tmo_sav", s_avalid, 0);

    s_rvalid = 1; s_rdata = 32'h99;
    tick();
    s_rvalid = 0;
    chk("late_rv", m_rvalid, 0);
    chk("late_rd", m_rdata, ERRD);

    // second timeout keeps the first address
    issue(32'h40, 4'hF);
    repeat (TMO) tick();
    chk("tmo2_err", err, 1);
    chk("tmo2_eaddr", err_addr, 32'h30);
    chk("tmo2_rv", m_rvalid, 0);
    chk("tmo2_rdy", m_ready, 1);
`ifdef IOB_PBUS_GUARD_ERR_CNT_EN
    chk("tmo2_cnt", err_cnt, 2);
`endif

    err_clr = 1;
    tick();
    err_clr = 0;
    chk("clr_err", err, 0);
`ifdef IOB_PBUS_GUARD_ERR_CNT_EN
    chk("clr_cnt", err_cnt, 0);
`endif

    // clear and timeout together: timeout wins
    issue(32'h50, 4'h0);
    repeat (TMO - 1) tick();
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("clrtmo_err", err, 1);
    chk("clrtmo_eaddr", err_addr, 32'h50);
    chk("clrtmo_rv", m_rvalid, 1);
`ifdef IOB_PBUS_GUARD_ERR_CNT_EN
    chk("clrtmo_cnt", err_cnt, 1);
`endif

    // clock enable low freezes the timeout counter
    issue(32'h70, 4'h0);
    cke = 0;
    repeat (20) tick();
    chk("cke_sav", s_avalid, 1);
    chk("cke_rv", m_rvalid, 0);
    chk("cke_rdy", m_ready, 0);
    cke = 1;
    repeat (TMO - 1) tick();
    chk("cke_wait_rv", m_rvalid, 0);
    tick();
    chk("cke_tmo_rv", m_rvalid, 1);
    chk("cke_tmo_rd", m_rdata, ERRD);
    chk("cke_eaddr", err_addr, 32'h50);

    err_clr = 1;
    tick();
    err_clr = 0;
    chk("clr2_err", err, 0);

    // read data on the last allowed cycle completes normally
    issue(32'h80, 4'h0);
    s_ready = 1;
    tick();
    s_ready = 0;
    repeat (TMO - 2) tick();
    s_rvalid = 1; s_rdata = 32'h1111;
    tick();
    s_rvalid = 0;
    chk("edge_rv", m_rvalid, 1);
    chk("edge_rd", m_rdata, 32'h1111);
    chk("edge_err", err, 0);

    issue(32'h84, 4'hF);
    repeat (TMO - 2) tick();
    s_ready = 1;
    tick();
    s_ready = 0;
    chk("edgew_err", err, 0);
    chk("edgew_rdy", m_ready, 1);
    chk("edgew_sav", s_avalid, 0);

    // reset while waiting for acknowledge
    issue(32'h90, 4'hF);
    tick();
    rst_n = 0;
    tick();
    chk("rack_rdy", m_ready, 0);
    chk("rack_rv", m_rvalid, 0);
    chk("rack_rd", m_rdata, 0);
    chk("rack_sav", s_avalid, 0);
    chk("rack_sad", s_addr, 0);
    chk("rack_swd", s_wdata, 0);
    chk("rack_sws", s_wstrb, 0);
    chk("rack_err", err, 0);
    chk("rack_eaddr", err_addr, 0);
    rst_n = 1;
    tick();
    chk("rel_rdy", m_ready, 1);

`ifdef IOB_PBUS_GUARD_ERR_CNT_EN
    for (int k = 0; k < 300; k++) begin
      issue(32'hA0, 4'hF);
      repeat (TMO) tick();
    end
    chk("sat_cnt", err_cnt, 255);
    chk("sat_err", err, 1);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("sat_clr", err_cnt, 0);
`endif

    // random traffic against the reference model
    rst_n = 0;
    model_step();
    tick();
    for (int c = 0; c < 4000; c++) begin
      rst_n    = ($urandom_range(0, 299) != 0);
      cke      = ($urandom_range(0, 7) != 0);
      m_avalid = $urandom_range(0, 1);
      m_addr   = $urandom;
      m_wdata  = $urandom;
      m_wstrb  = $urandom_range(0, 1) ? 4'h0
               : 4'($urandom_range(1, 15));
      s_ready  = ($urandom_range(0, 3) == 0);
      s_rvalid = ($urandom_range(0, 4) == 0);
      s_rdata  = $urandom;
      err_clr  = ($urandom_range(0, 31) == 0);
      model_step();
      tick();
      chk("r_rdy", m_ready, e_rdy);
      chk("r_rv", m_rvalid, e_rv);
      chk("r_rd", m_rdata, e_rd);
      chk("r_sav", s_avalid, e_sav);
      chk("r_sad", s_addr, e_sad);
      chk("r_swd", s_wdata, e_swd);
      chk("r_sws", s_wstrb, e_sws);
      chk("r_err", err, e_err);
      chk("r_eaddr", err_addr, e_ead);
`ifdef IOB_PBUS_GUARD_ERR_CNT_EN
      chk("r_cnt", err_cnt, 64'(e_cnt));
`endif
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/iob_pbus_guard.md
Name: iob_pbus_guard

Overview:
- Per-slave guard stage placed directly downstream of the peripheral-bus splitter, between one splitter slave port and one peripheral.
- Registers each IOb-native request and forwards it to the peripheral, one transaction outstanding at a time.
- Returns the peripheral's response to the splitter.
- A peripheral that never acknowledges or never returns read data cannot hang the CPU. After TIMEOUT cycles the guard completes the transaction itself with ERR_DATA and raises a sticky error.

Parameters:
- ADDR_W, 32, request address width
- DATA_W, 32, data width; wstrb width is DATA_W/8
- TIMEOUT, 256, cycles allowed from forwarding a request to its completion; must be ≥2
- TIMEOUT_W, 9, counter width; must satisfy 2^TIMEOUT_W > TIMEOUT
- ERR_DATA, 32'hDEADBEEF, read data returned on timeout

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- cke_i  in  1  clock enable; when low, all state holds
- m_avalid_i  in  1  request valid from splitter
- m_addr_i  in  ADDR_W  request address
- m_wdata_i  in  DATA_W  write data
- m_wstrb_i  in  DATA_W/8  write strobes; nonzero means write, zero means read
- m_rdata_o  out  DATA_W  read data to splitter
- m_rvalid_o  out  1  read data valid, one-cycle pulse
- m_ready_o  out  1  request accepted when m_avalid_i && m_ready_o
- s_avalid_o  out  1  request valid to peripheral
- s_addr_o  out  ADDR_W  request address to peripheral
- s_wdata_o  out  DATA_W  write data to peripheral
- s_wstrb_o  out  DATA_W/8  write strobes to peripheral
- s_rdata_i  in  DATA_W  read data from peripheral
- s_rvalid_i  in  1  read data valid from peripheral
- s_ready_i  in  1  peripheral accepts request
- err_o  out  1  sticky timeout flag
- err_addr_o  out  ADDR_W  address of the first timed-out request since the last clear
- err_clr_i  in  1  clears err_o

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_n_i; the polarity and synchronicity are fixed.
- Reset values (rst_n_i low at a clk_i edge, regardless of cke_i):
  - state=IDLE.
  - m_ready_o, m_rvalid_o, s_avalid_o, err_o = 0.
  - m_rdata_o, s_addr_o, s_wdata_o, s_wstrb_o, err_addr_o = 0; counter = 0.
- All outputs are registered. m_ready_o rises the first enabled cycle after reset release.
- cke_i=0: no state, counter or output register changes.
- States: IDLE, ACK (s_avalid_o=1, waiting s_ready_i), RDATA (waiting s_rvalid_i).
- IDLE:
  - m_ready_o=1.
  - On m_avalid_i: capture addr, wdata and wstrb into the s_* registers; drop m_ready_o; set s_avalid_o; counter=0; go to ACK.
  - Forwarding latency is 1 cycle.
- ACK:
  - s_* outputs are held stable. Counter increments each enabled cycle.
  - s_ready_i with write: drop s_avalid_o; go to IDLE (m_ready_o=1 next cycle).
  - s_ready_i with read: drop s_avalid_o; go to RDATA. The counter keeps running.
  - s_ready_i and s_rvalid_i in the same cycle (zero-latency read): complete directly. m_rdata_o=s_rdata_i and m_rvalid_o=1 next cycle; go to IDLE.
- RDATA: on s_rvalid_i, m_rdata_o=s_rdata_i and m_rvalid_o=1 for exactly one cycle; go to IDLE.
- Timeout: counter==TIMEOUT-1 in ACK or RDATA with no completion that cycle.
  - Drop s_avalid_o.
  - For a read: m_rdata_o=ERR_DATA, m_rvalid_o pulse.
  - Set err_o. Load err_addr_o only if err_o was 0.
  - Go to IDLE.
  - A completion in the same cycle as the timeout has priority; no error is raised.
- Late responses: s_rvalid_i or s_ready_i seen in IDLE are ignored and never forwarded.
- err_clr_i clears err_o; a timeout in the same cycle wins (err_o stays 1).
- m_rdata_o holds its last value between pulses.

Optional Feature:
- Macro: IOB_PBUS_GUARD_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt_o [7:0], reset 0.
  - err_cnt_o increments on every timeout and saturates at 255.
  - err_clr_i also clears err_cnt_o; a simultaneous timeout leaves err_cnt_o=1.
- Undefined: no err_cnt_o port and no counter logic.

Test Plan:
- Write addr=0x10, wdata=0x1234, wstrb=0xF; peripheral ready 2 cycles after s_avalid_o -> s_* outputs match; m_ready_o back to 1 three cycles after acceptance; err_o=0.
- Read addr=0x20; peripheral ready immediately, rvalid 3 cycles later with data 0xCAFE0001 -> one m_rvalid_o pulse with m_rdata_o=0xCAFE0001.
- Zero-latency read (s_ready_i and s_rvalid_i in the same cycle, data 0x55) -> m_rvalid_o next cycle, data 0x55, state IDLE.
- TIMEOUT=8, read addr=0x30, peripheral silent -> after 8 cycles m_rvalid_o pulse with 0xDEADBEEF, err_o=1, err_addr_o=0x30; a second timeout at 0x40 leaves err_addr_o=0x30.
- Late s_rvalid_i arriving after a timeout -> no m_rvalid_o. err_clr_i pulse -> err_o=0. Reset asserted while in ACK -> all outputs 0 next cycle.
- With IOB_PBUS_GUARD_ERR_CNT_EN: 300 consecutive timeouts -> err_cnt_o=255; err_clr_i -> 0.
